// File: rtl/ccd_reg_scheduler_if.sv
// Bundle between the exposure/gain scheduler, the user controls, the frame timing
// and the I2C master request port.
interface ccd_reg_scheduler_if;
    logic        exp_up;
    logic        exp_dn;
    logic [5:0]  gain;
    logic        fval;
    logic        i2c_req;
    logic [31:0] i2c_data;
    logic        i2c_ack;
    logic        i2c_err;
    logic [15:0] exposure;
    logic        busy;
    logic [7:0]  err_cnt;

    modport master (
        input  exp_up, exp_dn, gain, fval, i2c_ack, i2c_err,
        output i2c_req, i2c_data, exposure, busy, err_cnt
    );

    modport slave (
        output exp_up, exp_dn, gain, fval, i2c_ack, i2c_err,
        input  i2c_req, i2c_data, exposure, busy, err_cnt
    );
endinterface

// File: rtl/ccd_reg_scheduler.sv
// Sensor exposure/gain write scheduler: tracks user settings and pushes changed values
// to the sensor over I2C only while the frame is in vertical blanking.
module ccd_reg_scheduler #(
    parameter logic [7:0]  DEV_ADDR    = 8'hBA,
    parameter logic [7:0]  EXP_REG     = 8'h09,
    parameter logic [7:0]  GAIN_REG    = 8'h35,
    parameter logic [15:0] EXP_DEFAULT = 16'h0400,
    parameter logic [15:0] EXP_STEP    = 16'h0100,
    parameter logic [15:0] EXP_MIN     = 16'h0100,
    parameter logic [15:0] EXP_MAX     = 16'hFF00,
    parameter logic [19:0] TIMEOUT     = 20'd1000000
) (
    input logic                    clk,
    input logic                    rst,
    ccd_reg_scheduler_if.master    bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

    state_t      state, state_next;
    logic        up_q, dn_q, fval_q;
    logic [15:0] exposure, exp_next;
    logic        exp_pend, gain_pend;
    logic [5:0]  last_gain;
    logic        armed, exp_tried, gain_tried;
    logic        flight_is_gain;
    logic [19:0] to_cnt;
    logic        req;
    logic [31:0] data;
    logic [7:0]  err_cnt;

    logic up_edge, dn_edge, fval_fall, fval_rise, window;
    logic want_exp, want_gain, exp_change;
    logic issue_exp, issue_gain, ack_ok, fail;

    function automatic logic [15:0] step_up(input logic [15:0] v);
        logic [16:0] s;
        s = {1'b0, v} + {1'b0, EXP_STEP};
        return (s > {1'b0, EXP_MAX}) ? EXP_MAX : s[15:0];
    endfunction

    function automatic logic [15:0] step_down(input logic [15:0] v);
        logic [16:0] d;
        d = {1'b0, v} - {1'b0, EXP_STEP};
        return (d[16] || (d[15:0] < EXP_MIN)) ? EXP_MIN : d[15:0];
    endfunction

    assign up_edge   = bus.exp_up & ~up_q;
    assign dn_edge   = bus.exp_dn & ~dn_q;
    assign fval_fall = fval_q & ~bus.fval;
    assign fval_rise = ~fval_q & bus.fval;
    // The falling edge opens the window in the same cycle to save one cycle of latency.
    assign window    = (armed | fval_fall) & ~bus.fval;
    assign want_exp  = exp_pend & (fval_fall | ~exp_tried);
    assign want_gain = gain_pend & (fval_fall | ~gain_tried);

    always_comb begin
        exp_next = exposure;
        if (up_edge && !dn_edge)
            exp_next = step_up(exposure);
        else if (dn_edge && !up_edge)
            exp_next = step_down(exposure);
    end

    assign exp_change = (exp_next != exposure);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue_exp  = 1'b0;
        issue_gain = 1'b0;
        ack_ok     = 1'b0;
        fail       = 1'b0;
        case (state)
            IDLE: begin
                if (window && (want_exp || want_gain)) begin
                    state_next = REQ;
                    issue_exp  = want_exp;
                    issue_gain = ~want_exp;
                end
            end
            REQ: state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.i2c_ack) begin
                    state_next = IDLE;
                    ack_ok     = ~bus.i2c_err;
                    fail       = bus.i2c_err;
                end else if (to_cnt == TIMEOUT - 20'd1) begin
                    state_next = IDLE;
                    fail       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q           <= 1'b0;
            dn_q           <= 1'b0;
            fval_q         <= 1'b0;
            exposure       <= EXP_DEFAULT;
            exp_pend       <= 1'b1;
            gain_pend      <= 1'b1;
            last_gain      <= 6'd0;
            armed          <= 1'b0;
            exp_tried      <= 1'b0;
            gain_tried     <= 1'b0;
            flight_is_gain <= 1'b0;
            to_cnt         <= 20'd0;
            req            <= 1'b0;
            data           <= 32'd0;
            err_cnt        <= 8'd0;
        end else begin
            up_q     <= bus.exp_up;
            dn_q     <= bus.exp_dn;
            fval_q   <= bus.fval;
            exposure <= exp_next;

            // Each register gets at most one attempt per blanking window.
            if (fval_fall) begin
                armed      <= 1'b1;
                exp_tried  <= issue_exp;
                gain_tried <= issue_gain;
            end else begin
                if (fval_rise)
                    armed <= 1'b0;
                if (issue_exp)
                    exp_tried <= 1'b1;
                if (issue_gain)
                    gain_tried <= 1'b1;
                if ((issue_exp && gain_tried) || (issue_gain && exp_tried))
                    armed <= 1'b0;
            end

            // A value that moved while in flight keeps its pending flag.
            if (exp_change)
                exp_pend <= 1'b1;
            else if (ack_ok && !flight_is_gain && (exposure == data[15:0]))
                exp_pend <= 1'b0;

            if (ack_ok && flight_is_gain && (bus.gain == data[5:0])) begin
                gain_pend <= 1'b0;
                last_gain <= data[5:0];
            end else if (bus.gain != last_gain) begin
                gain_pend <= 1'b1;
            end

            if (issue_exp) begin
                data           <= {DEV_ADDR, EXP_REG, exposure};
                flight_is_gain <= 1'b0;
            end else if (issue_gain) begin
                data           <= {DEV_ADDR, GAIN_REG, 10'd0, bus.gain};
                flight_is_gain <= 1'b1;
            end

            if (state == REQ)
                req <= 1'b1;
            else if (ack_ok || fail)
                req <= 1'b0;

            if (state == REQ)
                to_cnt <= 20'd0;
            else if (state == WAIT_ACK)
                to_cnt <= to_cnt + 20'd1;

            if (fail && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.i2c_req  = req;
    assign bus.i2c_data = data;
    assign bus.exposure = exposure;
    assign bus.busy     = (state == REQ) || (state == WAIT_ACK);
    assign bus.err_cnt  = err_cnt;
endmodule

// File: tb/tb_ccd_reg_scheduler.sv
// Bench for ccd_reg_scheduler: directed scenarios plus randomized frames checked
// against a transaction-level model of the exposure/gain settings and blanking writes.
module tb_ccd_reg_scheduler;
    localparam logic [19:0] TO = 20'd40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ccd_reg_scheduler_if bus();

    ccd_reg_scheduler #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int m_exp;
    bit m_exp_pend;
    bit m_gain_pend;
    int m_last_gain;
    int m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic void model_reset();
        m_exp       = 32'h0400;
        m_exp_pend  = 1'b1;
        m_gain_pend = 1'b1;
        m_last_gain = 0;
        m_err       = 0;
    endfunction

    function automatic void model_key(input bit up, input bit dn);
        int n;
        n = m_exp;
        if (up && !dn)
            n = (m_exp + 32'h100 > 32'hFF00) ? 32'hFF00 : m_exp + 32'h100;
        else if (dn && !up)
            n = (m_exp - 32'h100 < 32'h100) ? 32'h100 : m_exp - 32'h100;
        if (n != m_exp) begin
            m_exp      = n;
            m_exp_pend = 1'b1;
        end
    endfunction

    function automatic void model_result(input logic [31:0] wr, input bit err);
        if (err) begin
            if (m_err < 255) m_err++;
        end else if (wr[23:16] == 8'h09) begin
            if (int'(wr[15:0]) == m_exp) m_exp_pend = 1'b0;
        end else begin
            if (wr[5:0] == bus.gain) begin
                m_gain_pend = 1'b0;
                m_last_gain = int'(wr[5:0]);
            end
        end
    endfunction

    task automatic press(input bit up, input bit dn);
        @(negedge clk);
        bus.exp_up = up;
        bus.exp_dn = dn;
        @(negedge clk);
        bus.exp_up = 1'b0;
        bus.exp_dn = 1'b0;
        model_key(up, dn);
    endtask

    task automatic set_gain(input logic [5:0] g);
        @(negedge clk);
        bus.gain = g;
        if (int'(g) != m_last_gain) m_gain_pend = 1'b1;
    endtask

    task automatic frame(input int cycles);
        @(negedge clk);
        bus.fval = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] want);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.i2c_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.i2c_req)
            check({tag, "_timeout"}, bus.i2c_req, 1'b1);
        else
            check(tag, bus.i2c_data, want);
    endtask

    task automatic send_ack(input bit err, input logic [31:0] wr);
        @(negedge clk);
        bus.i2c_ack = 1'b1;
        bus.i2c_err = err;
        model_result(wr, err);
        @(negedge clk);
        bus.i2c_ack = 1'b0;
        bus.i2c_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One blanking interval with a randomly timed (and optionally failing) responder.
    task automatic run_blank(input int err_pct);
        logic [31:0] q[$];
        logic [31:0] cur;
        bit          in_tx;
        bit          e;
        int          dly;
        int          exp_n;
        int          seen;
        q.delete();
        if (m_exp_pend)  q.push_back({8'hBA, 8'h09, m_exp[15:0]});
        if (m_gain_pend) q.push_back({8'hBA, 8'h35, 10'd0, bus.gain});
        exp_n = q.size();
        seen  = 0;
        in_tx = 1'b0;
        dly   = 0;
        cur   = 32'd0;
        @(negedge clk);
        bus.fval = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.i2c_ack = 1'b0;
            bus.i2c_err = 1'b0;
            if (in_tx) begin
                if (dly == 0) begin
                    e = ($urandom_range(99) < err_pct);
                    bus.i2c_ack = 1'b1;
                    bus.i2c_err = e;
                    model_result(cur, e);
                    in_tx = 1'b0;
                end else begin
                    dly--;
                end
            end else if (bus.i2c_req) begin
                cur = bus.i2c_data;
                seen++;
                if (q.size() > 0) check("blank_data", cur, q.pop_front());
                in_tx = 1'b1;
                dly   = $urandom_range(4);
            end
        end
        @(negedge clk);
        bus.i2c_ack = 1'b0;
        bus.i2c_err = 1'b0;
        @(negedge clk);
        check("blank_writes", seen, exp_n);
        check("blank_busy", bus.busy, 1'b0);
        check("blank_err_cnt", bus.err_cnt, m_err[7:0]);
        check("blank_exposure", bus.exposure, m_exp[15:0]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.exp_up  = 1'b0;
        bus.exp_dn  = 1'b0;
        bus.gain    = 6'h2A;
        bus.fval    = 1'b1;
        bus.i2c_ack = 1'b0;
        bus.i2c_err = 1'b0;
        do_reset();

        check("rst_exposure", bus.exposure, 16'h0400);
        check("rst_req", bus.i2c_req, 1'b0);
        check("rst_data", bus.i2c_data, 32'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err_cnt", bus.err_cnt, 8'h0);

        // First blanking after reset: latency, then exposure then gain.
        frame(5);
        @(negedge clk);
        bus.fval = 1'b0;
        @(posedge clk); #1;
        check("lat_cycle1_req", bus.i2c_req, 1'b0);
        @(posedge clk); #1;
        check("lat_cycle2_req", bus.i2c_req, 1'b1);
        check("first_exp_data", bus.i2c_data, 32'hBA090400);
        check("first_busy", bus.busy, 1'b1);
        send_ack(1'b0, 32'hBA090400);
        wait_req("first_gain_data", 32'hBA35002A);
        send_ack(1'b0, 32'hBA35002A);
        repeat (3) @(negedge clk);
        check("first_done_busy", bus.busy, 1'b0);

        // Three steps up inside a frame produce a single write.
        frame(3);
        press(1, 0); press(1, 0); press(1, 0);
        check("up3_exposure", bus.exposure, 16'h0700);
        run_blank(0);

        // NACK, then retry in the following blank.
        frame(3);
        press(1, 0);
        run_blank(100);
        check("nack_err_cnt", bus.err_cnt, 8'd1);
        frame(5);
        run_blank(0);

        // Withheld ACK aborts after the timeout.
        frame(3);
        press(1, 0);
        @(negedge clk);
        bus.fval = 1'b0;
        wait_req("to_req", 32'hBA090900);
        repeat (int'(TO) - 3) @(negedge clk);
        check("to_hold_req", bus.i2c_req, 1'b1);
        n = 0;
        while (bus.i2c_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("to_abort_req", bus.i2c_req, 1'b0);
        if (m_err < 255) m_err++;
        check("to_err_cnt", bus.err_cnt, 8'd2);
        repeat (40) @(negedge clk);
        frame(5);
        run_blank(0);

        // Reset while waiting for ACK, then a stray ACK in IDLE.
        frame(3);
        press(1, 0);
        @(negedge clk);
        bus.fval = 1'b0;
        wait_req("rstw_req", 32'hBA090A00);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_req_drop", bus.i2c_req, 1'b0);
        check("rstw_exposure", bus.exposure, 16'h0400);
        check("rstw_busy", bus.busy, 1'b0);
        rst = 1'b0;
        model_reset();
        bus.i2c_ack = 1'b1;
        @(negedge clk);
        bus.i2c_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", bus.i2c_req, 1'b0);
        check("late_ack_busy", bus.busy, 1'b0);
        check("late_ack_err", bus.err_cnt, 8'd0);

        // Both values pending after reset; exposure changes while its write is in flight.
        frame(5);
        @(negedge clk);
        bus.fval = 1'b0;
        wait_req("fl_exp_data", 32'hBA090400);
        press(1, 0);
        send_ack(1'b0, 32'hBA090400);
        wait_req("fl_gain_data", {8'hBA, 8'h35, 10'd0, bus.gain});
        send_ack(1'b0, {8'hBA, 8'h35, 10'd0, bus.gain});
        repeat (3) @(negedge clk);
        check("fl_exposure", bus.exposure, 16'h0500);
        frame(5);
        run_blank(0);

        // Upper and lower clamps.
        frame(2);
        n = 0;
        while (m_exp != 32'hFF00 && n < 300) begin
            press(1, 0);
            n++;
        end
        check("clamp_hi_reach", bus.exposure, 16'hFF00);
        run_blank(0);
        frame(3);
        press(1, 0);
        check("clamp_hi_hold", bus.exposure, 16'hFF00);
        run_blank(0);
        frame(2);
        n = 0;
        while (m_exp != 32'h100 && n < 300) begin
            press(0, 1);
            n++;
        end
        check("clamp_lo_reach", bus.exposure, 16'h0100);
        run_blank(0);
        frame(3);
        press(0, 1);
        check("clamp_lo_hold", bus.exposure, 16'h0100);
        run_blank(0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            frame($urandom_range(2, 6));
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: press(1, 0);
                    4, 5, 6:    press(0, 1);
                    7:          press(1, 1);
                    default:    set_gain(6'($urandom_range(0, 63)));
                endcase
            end
            repeat (3) @(negedge clk);
            check("rand_exposure", bus.exposure, m_exp[15:0]);
            run_blank(25);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
